// File: rtl/pixel_req_gen.sv
// Pixel-side request generator: latches ON/OFF events per pixel, drives
// polarity-coded requests into the round-robin arbiter, retires them with a
// four-phase request/grant handshake and a refractory hold-off, and counts
// events lost to busy or disabled pixels.

package arbiter_pkg;
    localparam int unsigned ROWS     = 4;
    localparam int unsigned COLS     = 4;
    localparam int unsigned POLARITY = 2;
endpackage

module pixel_req_gen #(
    parameter int unsigned ROWS           = arbiter_pkg::ROWS,
    parameter int unsigned COLS           = arbiter_pkg::COLS,
    parameter int unsigned POLARITY       = arbiter_pkg::POLARITY,
    parameter int unsigned REFRACT_CYCLES = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      enable_i,
    input  logic [ROWS-1:0][COLS-1:0]                 evt_on_i,
    input  logic [ROWS-1:0][COLS-1:0]                 evt_off_i,
    input  logic [ROWS-1:0][COLS-1:0]                 gnt_i,
    output logic [COLS-1:0][POLARITY-1:0][ROWS-1:0]   req_o,
    output logic [CNT_W-1:0]                          drop_cnt_o,
    output logic                                      busy_o,
    output logic                                      err_o
);

    localparam int unsigned RC_W   = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;
    localparam int unsigned DROP_W = $clog2(2 * ROWS * COLS + 1);
    localparam int unsigned SUM_W  = ((CNT_W > DROP_W) ? CNT_W : DROP_W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_ACK     = 2'd2,
        ST_REFRACT = 2'd3
    } state_e;

    state_e                state_q [ROWS][COLS];
    state_e                state_d [ROWS][COLS];
    logic [POLARITY-1:0]   pol_q   [ROWS][COLS];
    logic [POLARITY-1:0]   pol_d   [ROWS][COLS];
    logic [RC_W-1:0]       cnt_q   [ROWS][COLS];
    logic [RC_W-1:0]       cnt_d   [ROWS][COLS];

    logic [COLS-1:0][POLARITY-1:0][ROWS-1:0] req_q, req_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [DROP_W-1:0]     drops;
    logic [SUM_W-1:0]      cnt_sum;

    // Per-pixel next state, drop population count and registered output decode
    always_comb begin
        drops  = '0;
        err_d  = err_q;
        busy_d = 1'b0;
        req_d  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                state_d[r][c] = state_q[r][c];
                pol_d[r][c]   = pol_q[r][c];
                cnt_d[r][c]   = cnt_q[r][c];
                unique case (state_q[r][c])
                    ST_IDLE: begin
                        if (gnt_i[r][c]) err_d = 1'b1;
                        if (enable_i && (evt_on_i[r][c] || evt_off_i[r][c])) begin
                            state_d[r][c] = ST_PEND;
                            // ON wins a simultaneous pair; the OFF is lost
                            pol_d[r][c] = evt_on_i[r][c] ? POLARITY'(2'b10) : POLARITY'(2'b01);
                            if (evt_on_i[r][c] && evt_off_i[r][c]) drops = drops + DROP_W'(1);
                        end else begin
                            drops = drops + DROP_W'(evt_on_i[r][c]) + DROP_W'(evt_off_i[r][c]);
                        end
                    end
                    ST_PEND: begin
                        if (gnt_i[r][c]) state_d[r][c] = ST_ACK;
                        drops = drops + DROP_W'(evt_on_i[r][c]) + DROP_W'(evt_off_i[r][c]);
                    end
                    ST_ACK: begin
                        if (!gnt_i[r][c]) begin
                            state_d[r][c] = (REFRACT_CYCLES == 0) ? ST_IDLE : ST_REFRACT;
                            cnt_d[r][c]   = RC_W'(REFRACT_CYCLES);
                        end
                        drops = drops + DROP_W'(evt_on_i[r][c]) + DROP_W'(evt_off_i[r][c]);
                    end
                    ST_REFRACT: begin
                        if (gnt_i[r][c]) err_d = 1'b1;
                        if (cnt_q[r][c] <= RC_W'(1)) state_d[r][c] = ST_IDLE;
                        else                         cnt_d[r][c] = cnt_q[r][c] - RC_W'(1);
                        drops = drops + DROP_W'(evt_on_i[r][c]) + DROP_W'(evt_off_i[r][c]);
                    end
                    default: state_d[r][c] = ST_IDLE;
                endcase
                if (state_d[r][c] != ST_IDLE) busy_d = 1'b1;
                // Request port is column-major with the polarity bit in the middle
                if (state_d[r][c] == ST_PEND) begin
                    for (int p = 0; p < POLARITY; p++) req_d[c][p][r] = pol_d[r][c][p];
                end
            end
        end
        // Saturating accumulate: any carry above CNT_W pins the counter at all-ones
        cnt_sum = SUM_W'(drop_cnt_q) + SUM_W'(drops);
        if (cnt_sum[SUM_W-1:CNT_W] != '0) drop_cnt_d = '1;
        else                               drop_cnt_d = CNT_W'(cnt_sum);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    state_q[r][c] <= ST_IDLE;
                    pol_q[r][c]   <= '0;
                    cnt_q[r][c]   <= '0;
                end
            end
            req_q      <= '0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pol_q      <= pol_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign req_o      = req_q;
    assign drop_cnt_o = drop_cnt_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_pixel_req_gen.sv
// Directed bench for pixel_req_gen: a default instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise counter saturation.

module tb_pixel_req_gen;

    localparam int unsigned R = 4;
    localparam int unsigned C = 4;

    logic                      clk;
    logic                      reset_n;
    logic                      enable;
    logic [R-1:0][C-1:0]       evt_on;
    logic [R-1:0][C-1:0]       evt_off;
    logic [R-1:0][C-1:0]       gnt;
    logic [C-1:0][1:0][R-1:0]  req;
    logic [C-1:0][1:0][R-1:0]  req4;
    logic [15:0]               drop;
    logic [3:0]                drop4;
    logic                      busy, busy4, err, err4;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;

    pixel_req_gen dut (
        .clk_i(clk), .reset_i(reset_n), .enable_i(enable),
        .evt_on_i(evt_on), .evt_off_i(evt_off), .gnt_i(gnt),
        .req_o(req), .drop_cnt_o(drop), .busy_o(busy), .err_o(err)
    );

    pixel_req_gen #(.CNT_W(4)) dut4 (
        .clk_i(clk), .reset_i(reset_n), .enable_i(enable),
        .evt_on_i(evt_on), .evt_off_i(evt_off), .gnt_i(gnt),
        .req_o(req4), .drop_cnt_o(drop4), .busy_o(busy4), .err_o(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards are sampled at the following edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] preq(input int r, input int c);
        return {req[c][1][r], req[c][0][r]};
    endfunction

    // Grant one cycle, release, then wait (bounded) for the pixel array to go idle
    task automatic finish_hs(input int r, input int c);
        gnt[r][c] = 1'b1;
        tick();
        gnt[r][c] = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("idle_after_hs", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        evt_on  = '0;
        evt_off = '0;
        gnt     = '0;
        #12;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        tick();

        // ON event on (1,2), one-cycle grant, refractory drain
        evt_on[1][2] = 1'b1;
        tick();
        evt_on[1][2] = 1'b0;
        chk("t1_req_c1", 32'(preq(1, 2)), 32'h2);
        chk("t1_busy_c1", 32'(busy), 32'd1);
        tick();
        chk("t1_req_c2", 32'(preq(1, 2)), 32'h2);
        tick();
        chk("t1_req_c3", 32'(preq(1, 2)), 32'h2);
        gnt[1][2] = 1'b1;
        tick();
        gnt[1][2] = 1'b0;
        chk("t1_req_c4", 32'(preq(1, 2)), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        chk("t1_busy_c8", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_c9", 32'(busy), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_drop", 32'(drop), 32'd0);

        // OFF on (0,0), 3-cycle grant, strobes during ACK and REFRACT are dropped
        evt_off[0][0] = 1'b1;
        tick();
        evt_off[0][0] = 1'b0;
        chk("t2_req_pend", 32'(preq(0, 0)), 32'h1);
        gnt[0][0] = 1'b1;
        tick();
        chk("t2_req_ack", 32'(preq(0, 0)), 32'h0);
        evt_off[0][0] = 1'b1;
        tick();
        evt_off[0][0] = 1'b0;
        tick();
        gnt[0][0] = 1'b0;
        tick();
        evt_off[0][0] = 1'b1;
        tick();
        evt_off[0][0] = 1'b0;
        exp_drop = 2;
        chk("t2_drop2", 32'(drop), 32'(exp_drop));
        chk("t2_req_refr", 32'(preq(0, 0)), 32'h0);
        tick();
        tick();
        evt_off[0][0] = 1'b1;
        tick();
        evt_off[0][0] = 1'b0;
        exp_drop = 3;
        chk("t2_rel4_dropped", 32'(drop), 32'(exp_drop));
        chk("t2_rel4_noreq", 32'(preq(0, 0)), 32'h0);
        evt_off[0][0] = 1'b1;
        tick();
        evt_off[0][0] = 1'b0;
        chk("t2_rel5_req", 32'(preq(0, 0)), 32'h1);
        finish_hs(0, 0);

        // Simultaneous ON and OFF on (3,3)
        evt_on[3][3]  = 1'b1;
        evt_off[3][3] = 1'b1;
        tick();
        evt_on[3][3]  = 1'b0;
        evt_off[3][3] = 1'b0;
        exp_drop += 1;
        chk("t3_req", 32'(preq(3, 3)), 32'h2);
        chk("t3_drop", 32'(drop), 32'(exp_drop));
        finish_hs(3, 3);

        // Disabled capture on all pixels, then a normal event
        enable = 1'b0;
        evt_on = '1;
        tick();
        evt_on = '0;
        enable = 1'b1;
        exp_drop += 16;
        chk("t4_req_none", 32'(req), 32'd0);
        chk("t4_drop", 32'(drop), 32'(exp_drop));
        chk("t4_busy", 32'(busy), 32'd0);
        evt_on[2][2] = 1'b1;
        tick();
        evt_on[2][2] = 1'b0;
        chk("t4_req_reen", 32'(preq(2, 2)), 32'h2);
        chk("t4_req_all", 32'(req), 32'(1) << (2 * R * 2 + 1 * R + 2));
        finish_hs(2, 2);

        // Grant to an idle pixel raises sticky err without disturbing it
        chk("t5_err_pre", 32'(err), 32'd0);
        gnt[2][1] = 1'b1;
        tick();
        gnt[2][1] = 1'b0;
        chk("t5_err_set", 32'(err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        tick();
        tick();
        chk("t5_err_sticky", 32'(err), 32'd1);
        evt_on[2][1] = 1'b1;
        tick();
        evt_on[2][1] = 1'b0;
        chk("t5_req_later", 32'(preq(2, 1)), 32'h2);
        finish_hs(2, 1);
        chk("t5_err_still", 32'(err), 32'd1);

        // Saturation on the 4-bit counter, then reset mid-PEND
        reset_n = 1'b0;
        #1;
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_drop", 32'(drop), 32'd0);
        reset_n = 1'b1;
        tick();
        enable = 1'b0;
        evt_on = 16'h3FFF;
        tick();
        chk("t6_drop4_14", 32'(drop4), 32'd14);
        evt_on = 16'h003F;
        tick();
        evt_on = '0;
        enable = 1'b1;
        chk("t6_drop4_sat", 32'(drop4), 32'd15);
        chk("t6_drop16_20", 32'(drop), 32'd20);
        evt_on[0][1] = 1'b1;
        tick();
        evt_on[0][1] = 1'b0;
        chk("t6_req_pend", 32'(preq(0, 1)), 32'h2);
        chk("t6_drop4_hold", 32'(drop4), 32'd15);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_req", 32'(req), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_drop", 32'(drop), 32'd0);
        chk("t6_async_drop4", 32'(drop4), 32'd0);
        chk("t6_async_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("t6_post_rst_req", 32'(req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
